// File: rtl/lcd_rom_arbiter.sv
// rtl/lcd_rom_arbiter.sv - display-priority picture ROM arbiter with gap-gated background reads (optional LCD_ROM_ARB_STATS_EN read counters)
module lcd_rom_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 24,
  parameter int ROM_LATENCY  = 1,
  parameter int BG_GAP       = 2,
  parameter int STARVE_LIMIT = 1024
) (
  input  logic              lcd_pclk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  input  logic              bg_req,
  input  logic [ADDR_W-1:0] bg_addr,
  output logic              bg_gnt,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_rd_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              disp_rd_valid,
  output logic              bg_rd_valid,
  output logic [1:0]        arb_state,
  output logic              bg_starve
`ifdef LCD_ROM_ARB_STATS_EN
  ,
  output logic [17:0]       disp_rd_cnt,
  output logic [17:0]       bg_rd_cnt
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DISP = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_BG   = 2'd3;

  localparam logic [7:0]  GAP8    = 8'(BG_GAP);
  localparam logic [15:0] LIMIT16 = 16'(STARVE_LIMIT);

  logic [7:0]             r_idle_cnt;
  logic [15:0]            r_wait_cnt;
  logic [15:0]            w_wait_nxt;
  logic                   w_starve_set;
  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;
  logic                   r_starve;
  logic [ROM_LATENCY-1:0] r_disp_tag;
  logic [ROM_LATENCY-1:0] r_bg_tag;

  // Display always wins; bg only after BG_GAP idle display cycles
  assign bg_gnt   = !disp_req && bg_req && (r_idle_cnt >= GAP8);
  assign rom_en   = disp_req | bg_gnt;
  assign rom_addr = disp_req ? disp_addr : bg_addr;
  assign rd_data  = rom_rd_data;

  assign disp_rd_valid = r_disp_tag[ROM_LATENCY-1];
  assign bg_rd_valid   = r_bg_tag[ROM_LATENCY-1];
  assign arb_state     = r_state;
  assign bg_starve     = r_starve;

  // Count display-idle cycles, saturating at the guard interval
  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle_cnt <= 8'd0;
    end else if (disp_req) begin
      r_idle_cnt <= 8'd0;
    end else if (r_idle_cnt < GAP8) begin
      r_idle_cnt <= r_idle_cnt + 8'd1;
    end
  end

  // Next bg wait count and the cycle it first reaches the starvation limit
  always_comb begin
    w_wait_nxt = r_wait_cnt;
    if (!bg_req || bg_gnt) begin
      w_wait_nxt = 16'd0;
    end else if (r_wait_cnt != 16'hFFFF) begin
      w_wait_nxt = r_wait_cnt + 16'd1;
    end
    w_starve_set = (w_wait_nxt == LIMIT16) && (r_wait_cnt != LIMIT16);
  end

  // Register the bg wait counter
  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= 16'd0;
    end else begin
      r_wait_cnt <= w_wait_nxt;
    end
  end

  // Sticky starvation flag; a new set beats a same-cycle frame_start clear
  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= 1'b0;
    end else if (w_starve_set) begin
      r_starve <= 1'b1;
    end else if (frame_start) begin
      r_starve <= 1'b0;
    end
  end

  // Classify this cycle's decision: DISP > BG > GAP > IDLE
  always_comb begin
    w_state_nxt = ST_IDLE;
    if (disp_req) begin
      w_state_nxt = ST_DISP;
    end else if (bg_gnt) begin
      w_state_nxt = ST_BG;
    end else if (bg_req) begin
      w_state_nxt = ST_GAP;
    end
  end

  // Register the arbitration state
  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Owner tags travel alongside the ROM read so data returns labelled
  generate
    if (ROM_LATENCY == 1) begin : g_tag1
      // Single-stage owner tag
      always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
          r_disp_tag <= '0;
          r_bg_tag   <= '0;
        end else begin
          r_disp_tag <= disp_req;
          r_bg_tag   <= bg_gnt;
        end
      end
    end else begin : g_tagn
      // Multi-stage owner tag shift register
      always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
          r_disp_tag <= '0;
          r_bg_tag   <= '0;
        end else begin
          r_disp_tag <= {r_disp_tag[ROM_LATENCY-2:0], disp_req};
          r_bg_tag   <= {r_bg_tag[ROM_LATENCY-2:0], bg_gnt};
        end
      end
    end
  endgenerate

`ifdef LCD_ROM_ARB_STATS_EN
  logic [17:0] r_disp_rd_cnt;
  logic [17:0] r_bg_rd_cnt;

  assign disp_rd_cnt = r_disp_rd_cnt;
  assign bg_rd_cnt   = r_bg_rd_cnt;

  // Per-frame issued-read counters; frame_start restarts with this cycle's read
  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp_rd_cnt <= 18'd0;
      r_bg_rd_cnt   <= 18'd0;
    end else if (frame_start) begin
      r_disp_rd_cnt <= {17'd0, disp_req};
      r_bg_rd_cnt   <= {17'd0, bg_gnt};
    end else begin
      if (disp_req && (r_disp_rd_cnt != 18'h3FFFF)) begin
        r_disp_rd_cnt <= r_disp_rd_cnt + 18'd1;
      end
      if (bg_gnt && (r_bg_rd_cnt != 18'h3FFFF)) begin
        r_bg_rd_cnt <= r_bg_rd_cnt + 18'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lcd_rom_arbiter.sv
// tb/tb_lcd_rom_arbiter.sv - directed self-checking bench for lcd_rom_arbiter
module tb_lcd_rom_arbiter;

  logic        lcd_pclk    = 1'b0;
  logic        rst_n       = 1'b0;
  logic        frame_start = 1'b0;
  logic        disp_req    = 1'b0;
  logic [15:0] disp_addr   = 16'd0;
  logic        bg_req      = 1'b0;
  logic [15:0] bg_addr     = 16'd0;
  logic [23:0] rom_rd_data = 24'd0;

  logic        a_bg_gnt, a_rom_en, a_dval, a_bval, a_starve;
  logic [15:0] a_rom_addr;
  logic [23:0] a_rd_data;
  logic [1:0]  a_state;
  logic        b_bg_gnt, b_rom_en, b_dval, b_bval, b_starve;
  logic [15:0] b_rom_addr;
  logic [23:0] b_rd_data;
  logic [1:0]  b_state;
`ifdef LCD_ROM_ARB_STATS_EN
  logic [17:0] a_dcnt, a_bcnt, b_dcnt, b_bcnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] a;

  lcd_rom_arbiter #(.ROM_LATENCY(1), .BG_GAP(2), .STARVE_LIMIT(8)) u_dut (
    .lcd_pclk(lcd_pclk), .rst_n(rst_n), .frame_start(frame_start),
    .disp_req(disp_req), .disp_addr(disp_addr), .bg_req(bg_req), .bg_addr(bg_addr),
    .bg_gnt(a_bg_gnt), .rom_en(a_rom_en), .rom_addr(a_rom_addr), .rom_rd_data(rom_rd_data),
    .rd_data(a_rd_data), .disp_rd_valid(a_dval), .bg_rd_valid(a_bval),
    .arb_state(a_state), .bg_starve(a_starve)
`ifdef LCD_ROM_ARB_STATS_EN
    , .disp_rd_cnt(a_dcnt), .bg_rd_cnt(a_bcnt)
`endif
  );

  lcd_rom_arbiter #(.ROM_LATENCY(3), .BG_GAP(2), .STARVE_LIMIT(8)) u_dut_l3 (
    .lcd_pclk(lcd_pclk), .rst_n(rst_n), .frame_start(frame_start),
    .disp_req(disp_req), .disp_addr(disp_addr), .bg_req(bg_req), .bg_addr(bg_addr),
    .bg_gnt(b_bg_gnt), .rom_en(b_rom_en), .rom_addr(b_rom_addr), .rom_rd_data(rom_rd_data),
    .rd_data(b_rd_data), .disp_rd_valid(b_dval), .bg_rd_valid(b_bval),
    .arb_state(b_state), .bg_starve(b_starve)
`ifdef LCD_ROM_ARB_STATS_EN
    , .disp_rd_cnt(b_dcnt), .bg_rd_cnt(b_bcnt)
`endif
  );

  always #5 lcd_pclk = ~lcd_pclk;

  // One-cycle ROM model: data = {A5, address}
  always @(posedge lcd_pclk) begin
    if (a_rom_en) rom_rd_data <= {8'hA5, a_rom_addr};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge lcd_pclk);
    #1;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_state", 32'(a_state), 32'd0);
    check("rst_gnt", 32'(a_bg_gnt), 32'd0);
    check("rst_rom_en", 32'(a_rom_en), 32'd0);
    check("rst_dval", 32'(a_dval), 32'd0);
    check("rst_bval", 32'(a_bval), 32'd0);
    check("rst_starve", 32'(a_starve), 32'd0);
    check("rst_dval_l3", 32'(b_dval), 32'd0);
    rst_n = 1'b1;

    // Display reads 0x10..0x12, valid one cycle later
    for (int i = 0; i < 5; i++) begin
      disp_req  = (i < 3);
      disp_addr = 16'h0010 + 16'(i);
      #1;
      if (i < 3) begin
        check("t1_rom_en", 32'(a_rom_en), 32'd1);
        check("t1_rom_addr", 32'(a_rom_addr), 32'h0010 + 32'(i));
        check("t1_gnt", 32'(a_bg_gnt), 32'd0);
      end
      check("t1_dval", 32'(a_dval), 32'((i >= 1) && (i <= 3)));
      check("t1_state", 32'(a_state), 32'((i >= 1) && (i <= 3)));
      if ((i >= 1) && (i <= 3)) begin
        a = 16'h0010 + 16'(i - 1);
        check("t1_rd_data", 32'(a_rd_data), {8'h00, 8'hA5, a});
      end
      check("t1_bval", 32'(a_bval), 32'd0);
      tick();
    end

    // Simultaneous disp and bg for 5 cycles
    for (int i = 0; i < 5; i++) begin
      disp_req  = 1'b1;
      disp_addr = 16'h0100 + 16'(i);
      bg_req    = 1'b1;
      bg_addr   = 16'h1234;
      #1;
      check("t3_gnt", 32'(a_bg_gnt), 32'd0);
      check("t3_rom_addr", 32'(a_rom_addr), 32'h0100 + 32'(i));
      tick();
    end
    check("t3_wait5", 32'(u_dut.r_wait_cnt), 32'd5);

    // Display drops: two GAP cycles, then bg grant
    disp_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t2_gnt", 32'(a_bg_gnt), 32'(i == 2));
      check("t2_state", 32'(a_state), (i == 0) ? 32'd1 : 32'd2);
      if (i == 2) check("t2_rom_addr", 32'(a_rom_addr), 32'h1234);
      tick();
    end
    bg_req = 1'b0;
    #1;
    check("t2_state_bg", 32'(a_state), 32'd3);
    check("t2_bval", 32'(a_bval), 32'd1);
    check("t2_dval", 32'(a_dval), 32'd0);
    check("t2_rd_data", 32'(a_rd_data), 32'hA51234);
    check("t2_wait_clr", 32'(u_dut.r_wait_cnt), 32'd0);
    check("t2_no_starve", 32'(a_starve), 32'd0);
    tick(); tick(); tick();
    check("idle_sat", 32'(u_dut.r_idle_cnt), 32'd2);

    // Starvation: display held 20 cycles with bg pending
    for (int i = 0; i < 20; i++) begin
      disp_req = 1'b1;
      bg_req   = 1'b1;
      bg_addr  = 16'h2222;
      #1;
      check("t4_gnt", 32'(a_bg_gnt), 32'd0);
      if (i == 7) check("t4_starve7", 32'(a_starve), 32'd0);
      if (i == 8) check("t4_starve8", 32'(a_starve), 32'd1);
      tick();
    end
    disp_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t4_gnt_gap", 32'(a_bg_gnt), 32'(i == 2));
      tick();
    end
    bg_req = 1'b0;
    #1;
    check("t4_starve_sticky", 32'(a_starve), 32'd1);
    check("t4_bval", 32'(a_bval), 32'd1);
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    #1;
    check("t4_starve_clr", 32'(a_starve), 32'd0);

    // Set beats same-cycle clear; dropped request clears the wait count
    for (int i = 0; i < 8; i++) begin
      disp_req    = 1'b1;
      bg_req      = 1'b1;
      frame_start = (i == 7);
      tick();
    end
    frame_start = 1'b0;
    #1;
    check("t4_set_wins", 32'(a_starve), 32'd1);
    bg_req = 1'b0;
    tick();
    check("t4_drop_wait", 32'(u_dut.r_wait_cnt), 32'd0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    disp_req    = 1'b0;
    #1;
    check("t4_starve_clr2", 32'(a_starve), 32'd0);
    repeat (4) tick();

    // Issue pattern D,-,-,B,D; latency 3 copy lags by exactly 3
    for (int i = 0; i < 11; i++) begin
      disp_req = (i == 0) || (i == 4);
      bg_req   = (i >= 1) && (i <= 3);
      bg_addr  = 16'h3333;
      #1;
      check("t5_gnt", 32'(a_bg_gnt), 32'(i == 3));
      check("t5_dval_l1", 32'(a_dval), 32'((i == 1) || (i == 5)));
      check("t5_bval_l1", 32'(a_bval), 32'(i == 4));
      check("t5_dval_l3", 32'(b_dval), 32'((i == 3) || (i == 7)));
      check("t5_bval_l3", 32'(b_bval), 32'(i == 6));
      tick();
    end

    // Reset with two display reads in flight
    disp_req = 1'b1;
    tick(); tick();
    disp_req = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("t6_dval_l1", 32'(a_dval), 32'd0);
    check("t6_dval_l3", 32'(b_dval), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t6_dval_l3_after", 32'(b_dval), 32'd0);
      check("t6_bval_l3_after", 32'(b_bval), 32'd0);
      tick();
    end

`ifdef LCD_ROM_ARB_STATS_EN
    // 250 display reads and 40 bg reads, then frame_start
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    disp_req    = 1'b1;
    repeat (250) tick();
    disp_req = 1'b0;
    bg_req   = 1'b1;
    repeat (42) tick();
    bg_req = 1'b0;
    #1;
    check("st_disp_cnt", 32'(a_dcnt), 32'd250);
    check("st_bg_cnt", 32'(a_bcnt), 32'd40);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    #1;
    check("st_disp_cnt_clr", 32'(a_dcnt), 32'd0);
    check("st_bg_cnt_clr", 32'(a_bcnt), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
